// File: rtl/layernorm_pkg.sv
// layernorm_pkg: shared LayerNorm fixed-point formats, default epsilon and stage FSM encoding
package layernorm_pkg;
  localparam int S5_10_WIDTH = 16;
  localparam int S5_10_FRAC = 10;
  localparam int S13_10_WIDTH = 24;
  localparam int S13_10_FRAC = 10;
  localparam int S3_20_WIDTH = 24;
  localparam int S3_20_FRAC = 20;
  localparam int DEFAULT_EPS = 10;
  typedef enum logic [2:0] {ST_IDLE, ST_PREP, ST_SQRT, ST_DIV, ST_DONE} ln_state_e;
endpackage

// File: rtl/layernorm_inv_sqrt_unit.sv
// layernorm_inv_sqrt_unit: variance -> std = sqrt(var+eps) and inv_std = 1/std via serial sqrt then serial divide
module layernorm_inv_sqrt_unit
  import layernorm_pkg::*;
#(
  parameter int VAR_WIDTH = S3_20_WIDTH,
  parameter int VAR_FRAC = S3_20_FRAC,
  parameter int OUT_WIDTH = 24,
  parameter int OUT_FRAC = 14,
  parameter int EPS = DEFAULT_EPS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [VAR_WIDTH-1:0]   variance_in,
  input  logic                   variance_valid,
  output logic [VAR_WIDTH/2-1:0] std_out,
  output logic [OUT_WIDTH-1:0]   inv_std_out,
  output logic                   inv_std_valid,
  output logic                   busy,
  output logic                   range_err,
  output logic                   overrun
);
  localparam int SW = VAR_WIDTH / 2;
  localparam int RW = SW + 2;
  localparam int QW = VAR_FRAC / 2 + OUT_FRAC + 1;
  localparam int CW = $clog2(QW);
  ln_state_e state, state_nxt;
  logic [VAR_WIDTH-1:0] var_q, rad;
  logic [RW-1:0] rem, rem_sh, trial;
  logic [SW:0] pr_sh;
  logic [SW-1:0] root;
  logic [QW-1:0] quo, quo_nxt;
  logic [CW-1:0] cnt;
  logic accept, sq_ge, div_ge, sat, last;
  assign accept = variance_valid && (state == ST_IDLE || state == ST_DONE);
  assign busy = state == ST_PREP || state == ST_SQRT || state == ST_DIV;
  assign inv_std_valid = state == ST_DONE;
  assign last = cnt == '0;
  assign rem_sh = {rem[RW-3:0], rad[VAR_WIDTH-1 -: 2]};
  assign trial = {root, 2'b01};
  assign sq_ge = rem_sh >= trial;
  // The dividend is a single power of two, so its only set bit enters on the first divide step.
  assign pr_sh = {rem[SW-1:0], cnt == CW'(QW - 1)};
  assign div_ge = pr_sh >= {1'b0, root};
  assign quo_nxt = {quo[QW-2:0], div_ge};
  assign sat = root == '0 || (64'(quo_nxt) >> OUT_WIDTH) != 64'd0;
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = accept ? ST_PREP : ST_IDLE;
      ST_PREP: state_nxt = ST_SQRT;
      ST_SQRT: state_nxt = last ? ST_DIV : ST_SQRT;
      ST_DIV:  state_nxt = last ? ST_DONE : ST_DIV;
      ST_DONE: state_nxt = accept ? ST_PREP : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      var_q <= '0;
      rad <= '0;
      rem <= '0;
      root <= '0;
      quo <= '0;
      cnt <= '0;
      std_out <= '0;
      inv_std_out <= '0;
      range_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= variance_valid && busy;
      if (accept) var_q <= variance_in;
      case (state)
        ST_PREP: begin
          rad <= var_q[VAR_WIDTH-1] ? VAR_WIDTH'(EPS) : var_q + VAR_WIDTH'(EPS);
          rem <= '0;
          root <= '0;
          cnt <= CW'(SW - 1);
        end
        ST_SQRT: begin
          rem <= sq_ge ? rem_sh - trial : rem_sh;
          root <= {root[SW-2:0], sq_ge};
          rad <= rad << 2;
          cnt <= cnt - CW'(1);
          if (last) begin
            rem <= '0;
            quo <= '0;
            cnt <= CW'(QW - 1);
          end
        end
        ST_DIV: begin
          rem <= RW'(div_ge ? pr_sh - {1'b0, root} : pr_sh);
          quo <= quo_nxt;
          cnt <= cnt - CW'(1);
          if (last) begin
            std_out <= root;
            inv_std_out <= sat ? '1 : OUT_WIDTH'(quo_nxt);
            range_err <= sat;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_layernorm_inv_sqrt_unit.sv
// tb_layernorm_inv_sqrt_unit: table-driven and sequence checks of the inverse-sqrt stage
module tb_layernorm_inv_sqrt_unit;
  typedef struct {
    bit          z;
    logic [23:0] v;
    logic [11:0] std;
    logic [23:0] inv;
    logic        err;
  } vec_t;
  logic clk = 0, rst_n = 0;
  logic [23:0] vin = 0, vin0 = 0;
  logic vv = 0, vv0 = 0;
  logic [11:0] std1, std0;
  logic [23:0] inv1, inv0;
  logic val1, val0, busy1, busy0, err1, err0, ovr1, ovr0;
  bit sel = 0;
  int pass = 0, total = 0;
  vec_t tv [7];
  wire [11:0] s_std = sel ? std0 : std1;
  wire [23:0] s_inv = sel ? inv0 : inv1;
  wire s_valid = sel ? val0 : val1;
  wire s_busy = sel ? busy0 : busy1;
  wire s_err = sel ? err0 : err1;
  always #5 clk = ~clk;
  layernorm_inv_sqrt_unit dut (
    .clk(clk), .rst_n(rst_n), .variance_in(vin), .variance_valid(vv),
    .std_out(std1), .inv_std_out(inv1), .inv_std_valid(val1), .busy(busy1),
    .range_err(err1), .overrun(ovr1)
  );
  layernorm_inv_sqrt_unit #(.EPS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .variance_in(vin0), .variance_valid(vv0),
    .std_out(std0), .inv_std_out(inv0), .inv_std_valid(val0), .busy(busy0),
    .range_err(err0), .overrun(ovr0)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic run_vec(input vec_t t, input string nm);
    int bad = 0;
    sel = t.z;
    if (t.z) begin vin0 = t.v; vv0 = 1; end
    else begin vin = t.v; vv = 1; end
    for (int k = 1; k <= 39; k++) begin
      @(negedge clk);
      vv = 0;
      vv0 = 0;
      if (s_busy !== (k <= 38) || s_valid !== (k == 39)) bad++;
    end
    check({nm, " busy/valid timing errors"}, bad, 0);
    check({nm, " std"}, 32'(s_std), 32'(t.std));
    check({nm, " inv_std"}, 32'(s_inv), 32'(t.inv));
    check({nm, " range_err"}, 32'(s_err), 32'(t.err));
  endtask
  initial begin
    int extra;
    tv[0] = '{0, 24'd1310720, 12'd1144, 24'd14665, 1'b0};
    tv[1] = '{0, 24'd1048576, 12'd1024, 24'd16384, 1'b0};
    tv[2] = '{0, 24'd0, 12'd3, 24'd5592405, 1'b0};
    tv[3] = '{0, 24'hF00000, 12'd3, 24'd5592405, 1'b0};
    tv[4] = '{0, 24'h7FFFFF, 12'd2896, 24'd5793, 1'b0};
    tv[5] = '{1, 24'd1, 12'd1, 24'hFFFFFF, 1'b1};
    tv[6] = '{1, 24'd0, 12'd0, 24'hFFFFFF, 1'b1};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset std", 32'(std1), 0);
    check("reset inv", 32'(inv1), 0);
    check("reset valid", 32'(val1), 0);
    check("reset busy", 32'(busy1), 0);
    check("reset err", 32'(err1), 0);
    check("reset overrun", 32'(ovr1), 0);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) run_vec(tv[i], $sformatf("vec%0d", i));
    sel = 0;
    @(negedge clk);
    check("idle after done valid", 32'(val1), 0);
    check("idle after done busy", 32'(busy1), 0);
    extra = 0;
    vin = 24'd1310720;
    vv = 1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 1) vv = 0;
      if (k == 10) begin
        check("overrun before", 32'(ovr1), 0);
        vin = 24'd0;
        vv = 1;
      end
      if (k == 11) begin
        vv = 0;
        check("overrun pulse", 32'(ovr1), 1);
      end
      if (k == 12) check("overrun single cycle", 32'(ovr1), 0);
      if (k == 39) begin
        check("overrun result valid", 32'(val1), 1);
        check("overrun result inv", 32'(inv1), 14665);
        check("overrun result std", 32'(std1), 1144);
      end else if (val1) extra++;
    end
    check("overrun extra valids", extra, 0);
    vin = 24'd1310720;
    vv = 1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) vv = 0;
    end
    check("mid-div busy", 32'(busy1), 1);
    rst_n = 0;
    #1;
    check("async reset std", 32'(std1), 0);
    check("async reset inv", 32'(inv1), 0);
    check("async reset valid", 32'(val1), 0);
    check("async reset busy", 32'(busy1), 0);
    check("async reset err", 32'(err1), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_vec(tv[0], "after reset");
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/layernorm_inv_sqrt_unit.md
# layernorm_inv_sqrt_unit

Sequential reciprocal-square-root stage that sits directly downstream of `variance_unit` in the LayerNorm datapath. It consumes the S3.20 variance, adds epsilon, and computes std = sqrt(var+eps) with a bit-serial restoring square root. It then computes inv_std = 1/std with a bit-serial restoring divider. inv_std feeds the normalize/scale stage.

## Interface
Parameters:
- `VAR_WIDTH` = 24: width of the variance input, S3.20; must be even.
- `VAR_FRAC` = 20: fractional bits of the variance; must be even.
- `OUT_WIDTH` = 24: width of `inv_std_out`, unsigned.
- `OUT_FRAC` = 14: fractional bits of `inv_std_out`.
- `EPS` = 10: epsilon in variance LSBs (≈1e-5 in Q.20).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `variance_in`  in  VAR_WIDTH  signed variance, S3.20.
- `variance_valid`  in  1  one-cycle pulse qualifying `variance_in`.
- `std_out`  out  VAR_WIDTH/2  sqrt(var+eps), unsigned, VAR_FRAC/2 fraction bits.
- `inv_std_out`  out  OUT_WIDTH  1/std, unsigned Q(OUT_WIDTH-OUT_FRAC).OUT_FRAC.
- `inv_std_valid`  out  1  one-cycle pulse when the outputs update.
- `busy`  out  1  high while a computation is in flight.
- `range_err`  out  1  qualified by `inv_std_valid`; high when the result saturated.
- `overrun`  out  1  one-cycle pulse when `variance_valid` arrives while busy.

## Operation
- Input capture and clamp:
  - Accept `variance_in` when `variance_valid`=1 and state is IDLE or DONE.
  - A negative input (MSB set) clamps to 0.
  - Radicand R = clamped + EPS, treated as a VAR_WIDTH-bit unsigned value. It cannot overflow, since positive max + EPS < 2^VAR_WIDTH.
- Square root:
  - Restoring integer sqrt of R, one result bit per cycle, VAR_WIDTH/2 = 12 iterations.
  - S = floor(sqrt(R)). S carries VAR_FRAC/2 = 10 fraction bits, because sqrt(v/2^20) = sqrt(v)/2^10.
- Division:
  - Dividend N = 1 << (VAR_FRAC/2 + OUT_FRAC) = 2^24.
  - Restoring divide Q = floor(N/S), one quotient bit per cycle, VAR_FRAC/2+OUT_FRAC+1 = 25 iterations, with a (VAR_WIDTH/2+1)-bit partial remainder.
- Saturation:
  - If S = 0, or Q ≥ 2^OUT_WIDTH: `inv_std_out` = all ones and `range_err` = 1.
  - Otherwise `inv_std_out` = Q[OUT_WIDTH-1:0] and `range_err` = 0.
- FSM: IDLE → PREP (1 cycle: clamp, add EPS) → SQRT (12 cycles) → DIV (25 cycles) → DONE (1 cycle) → IDLE.
  - In DONE, an accepted input goes directly to PREP.
- `variance_valid` in PREP, SQRT or DIV is dropped: `overrun` pulses, and the computation in flight is unaffected.
- `variance_valid` in DONE is accepted, not an overrun.

## Timing
- Reset (async assert, any state): state IDLE; `std_out`, `inv_std_out` = 0; `inv_std_valid`, `busy`, `range_err`, `overrun` = 0. All registers and the iteration counter are cleared, and a computation in flight is abandoned with no valid.
- Latency: take the accepting edge as E0. `inv_std_valid` is high in the cycle after edge E0+38, i.e. in state DONE, 39 cycles after acceptance.
- Output registers:
  - `std_out` and `inv_std_out` update on the same edge that raises `inv_std_valid`.
  - They hold until the next result.
- `busy`:
  - High from E0 through the DIV state.
  - Low in DONE and IDLE.
- Throughput: one result per 39 cycles when inputs are issued back-to-back in DONE.
- `overrun`: registered, high for exactly one cycle after the offending edge.

## Structure
- `layernorm_pkg` holds the shared constants, reused by the mean, variance and normalize stages:
  - the S5.10, S13.10 and S3.20 widths and fraction counts;
  - the default EPS;
  - the FSM state encoding.
- Single module; no sub-module required.
- The sqrt and divide iterations share one down-counter sized for the larger (25) count.

## Test plan
- Nominal: var 1.25 (1310720), EPS=10 → `std_out` 1144; `inv_std_out` 14665; `range_err` 0; valid exactly 39 cycles after acceptance; `busy` high for cycles 1–38.
- Unit variance, then zero variance, issued back-to-back with each new input in the DONE cycle:
  - 1048576 → 1024 / 16384.
  - 0 → 3 / 5592405.
- Clamp and max:
  - 24'hF00000 (negative) → 3 / 5592405.
  - 24'h7FFFFF → 2896 / 5793.
- Saturation with EPS=0:
  - var=1 → `inv_std_out` 24'hFFFFFF, `range_err` 1.
  - var=0 → 24'hFFFFFF, `range_err` 1.
- Overrun: second `variance_valid` at cycle 10 of a 1.25 computation → `overrun` one-cycle pulse; result still 14665; no second valid.
- Reset mid-DIV (cycle 20) → all outputs 0 immediately; a fresh 1.25 input after release yields 14665 after 39 cycles.
